// File: rtl/fb_write_sched.sv
// rtl/fb_write_sched.sv - frame-buffer write-port scheduler: clear engine plus button-driven cursor painter
module fb_write_sched #(
    parameter int              AW         = 8,
    parameter int              DW         = 3,
    parameter logic [DW-1:0]   CLR_COLOR  = 3'b000,
    parameter logic [DW-1:0]   CUR_COLOR  = 3'b100,
    parameter int              DEB_CYCLES = 250000,
    parameter int              DEB_W      = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vblank,
    input  logic          clr_req,
    input  logic          bntr,
    input  logic          bntl,
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          regwrite,
    output logic [AW-1:0] cursor,
    output logic          busy
);
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ERASE, S_PAINT} state_t;

    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES);

    state_t          r_state, w_state_nxt;
    logic [AW:0]     r_clr_addr, w_clr_addr_nxt;
    logic [AW-1:0]   r_addr, w_addr_nxt;
    logic [AW-1:0]   r_cursor, w_cursor_nxt, w_cursor_step;
    logic [DW-1:0]   r_data, w_data_nxt;
    logic            r_we, w_we_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_dir, w_dir_nxt;
    logic            r_clr_pend, w_clr_pend_nxt;
    logic            r_mv_r_pend, w_mv_r_pend_nxt;
    logic            r_mv_l_pend, w_mv_l_pend_nxt;
    logic [1:0]      w_btn, r_sync1, r_sync2, r_deb, w_rise;
    logic [DEB_W-1:0] r_deb_cnt [2];

    // index 0 = right button, index 1 = left button
    assign w_btn = {bntl, bntr};

    // two-flop synchroniser and debounce counter per button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_deb        <= '0;
            r_deb_cnt[0] <= '0;
            r_deb_cnt[1] <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_MAX) begin
                    r_deb[i]     <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // a debounced rising edge is the cycle the high level gets accepted
    always_comb begin
        w_rise = '0;
        for (int i = 0; i < 2; i++) begin
            w_rise[i] = r_sync2[i] & ~r_deb[i] & (r_deb_cnt[i] == DEB_MAX);
        end
    end

    assign w_cursor_step = r_dir ? (r_cursor + AW'(1)) : (r_cursor - AW'(1));

    // state and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_clr_addr  <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_we        <= 1'b0;
            r_cursor    <= '0;
            r_busy      <= 1'b0;
            r_dir       <= 1'b0;
            r_clr_pend  <= 1'b1;
            r_mv_r_pend <= 1'b0;
            r_mv_l_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_addr  <= w_clr_addr_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_we        <= w_we_nxt;
            r_cursor    <= w_cursor_nxt;
            r_busy      <= w_busy_nxt;
            r_dir       <= w_dir_nxt;
            r_clr_pend  <= w_clr_pend_nxt;
            r_mv_r_pend <= w_mv_r_pend_nxt;
            r_mv_l_pend <= w_mv_l_pend_nxt;
        end
    end

    // next-state and write-port decode; the write is registered on the edge that decides it
    always_comb begin
        logic w_take_clr, w_drop_r, w_drop_l;
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_we_nxt       = 1'b0;
        w_cursor_nxt   = r_cursor;
        w_busy_nxt     = r_busy;
        w_dir_nxt      = r_dir;
        w_take_clr     = 1'b0;
        w_drop_r       = 1'b0;
        w_drop_l       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_clr_pend) begin
                    w_state_nxt    = S_CLEAR;
                    w_clr_addr_nxt = '0;
                    w_busy_nxt     = 1'b1;
                    w_take_clr     = 1'b1;
                end else if (vblank && r_mv_r_pend && r_mv_l_pend) begin
                    // opposite moves cancel each other
                    w_drop_r = 1'b1;
                    w_drop_l = 1'b1;
                end else if (vblank && (r_mv_r_pend || r_mv_l_pend)) begin
                    w_state_nxt = S_ERASE;
                    w_dir_nxt   = r_mv_r_pend;
                    w_drop_r    = r_mv_r_pend;
                    w_drop_l    = r_mv_l_pend;
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = r_cursor;
                    w_data_nxt  = CLR_COLOR;
                end
            end
            S_CLEAR: begin
                // top bit of the clear counter marks the trailing cursor repaint
                if (vblank) begin
                    w_we_nxt = 1'b1;
                    if (!r_clr_addr[AW]) begin
                        w_addr_nxt     = r_clr_addr[AW-1:0];
                        w_data_nxt     = CLR_COLOR;
                        w_clr_addr_nxt = r_clr_addr + (AW+1)'(1);
                    end else begin
                        w_addr_nxt  = r_cursor;
                        w_data_nxt  = CUR_COLOR;
                        w_state_nxt = S_PAINT;
                    end
                end
            end
            S_ERASE: begin
                // paint is committed regardless of vblank once the erase went out
                w_cursor_nxt = w_cursor_step;
                w_we_nxt     = 1'b1;
                w_addr_nxt   = w_cursor_step;
                w_data_nxt   = CUR_COLOR;
                w_state_nxt  = S_PAINT;
            end
            S_PAINT: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_clr_pend_nxt  = clr_req | (r_clr_pend & ~w_take_clr);
        w_mv_r_pend_nxt = w_rise[0] | (r_mv_r_pend & ~w_drop_r);
        w_mv_l_pend_nxt = w_rise[1] | (r_mv_l_pend & ~w_drop_l);
    end

    assign addr_in  = r_addr;
    assign data_in  = r_data;
    assign regwrite = r_we;
    assign cursor   = r_cursor;
    assign busy     = r_busy;
endmodule

// File: tb/tb_fb_write_sched.sv
// tb/tb_fb_write_sched.sv - self-checking bench for fb_write_sched
module tb_fb_write_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vblank = 1'b0;
    logic       clr_req = 1'b0;
    logic       bntr = 1'b0;
    logic       bntl = 1'b0;
    logic [7:0] addr_in;
    logic [2:0] data_in;
    logic       regwrite;
    logic [7:0] cursor;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int got_q[$];
    int got_c[$];
    int exp_q[$];
    int m_cursor = 0;

    fb_write_sched #(
        .AW(8), .DW(3), .CLR_COLOR(3'b000), .CUR_COLOR(3'b100),
        .DEB_CYCLES(4), .DEB_W(3)
    ) dut (
        .clk(clk), .rst(rst), .vblank(vblank), .clr_req(clr_req),
        .bntr(bntr), .bntl(bntl), .addr_in(addr_in), .data_in(data_in),
        .regwrite(regwrite), .cursor(cursor), .busy(busy)
    );

    always #5 clk = ~clk;

    // record every RAM write as addr*8+data with its cycle number
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (regwrite === 1'b1) begin
            got_q.push_back(int'(addr_in) * 8 + int'(data_in));
            got_c.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        got_q.delete();
        got_c.delete();
        exp_q.delete();
    endtask

    // reference: a full clear writes every address with background, then repaints the cursor
    function automatic void exp_clear();
        for (int a = 0; a < 256; a++) exp_q.push_back(a * 8);
        exp_q.push_back(m_cursor * 8 + 4);
    endfunction

    // reference: a move erases the old cursor cell then paints the new one, modulo 256
    function automatic void exp_move(input bit right);
        exp_q.push_back(m_cursor * 8);
        m_cursor = right ? (m_cursor + 1) % 256 : (m_cursor + 255) % 256;
        exp_q.push_back(m_cursor * 8 + 4);
    endfunction

    // index of first disagreement between logs, or -1 when identical
    function automatic int log_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] != exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic int got_at(input int i);
        return (i >= 0 && i < got_q.size()) ? got_q[i] : -1;
    endfunction

    function automatic int exp_at(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : -1;
    endfunction

    task automatic wait_busy(input bit lvl, input int max, input string nm);
        int k = 0;
        while (busy !== lvl && k < max) begin
            tick(1);
            k++;
        end
        total++;
        if (busy !== lvl) begin
            bad++;
            $display("FAIL %s: busy=%0b after %0d cycles, required %0b", nm, busy, k, lvl);
        end
    endtask

    task automatic press(input bit r, input bit l, input int hi);
        bntr = r;
        bntl = l;
        tick(hi);
        bntr = 1'b0;
        bntl = 1'b0;
        tick(14);
    endtask

    task automatic pulse_clr();
        clr_req = 1'b1;
        tick(1);
        clr_req = 1'b0;
    endtask

    task automatic test_reset();
        vblank = 1'b1;
        #1 rst = 1'b0;
        tick(3);
        total++;
        if ({addr_in, data_in} !== 11'd0) begin
            bad++;
            $display("FAIL reset_addr_data: addr=%0d data=%0d, required 0 0", addr_in, data_in);
        end
        total++;
        if ({regwrite, busy} !== 2'b00) begin
            bad++;
            $display("FAIL reset_we_busy: regwrite=%0b busy=%0b, required 0 0", regwrite, busy);
        end
        total++;
        if (cursor !== 8'd0) begin
            bad++;
            $display("FAIL reset_cursor: cursor=%0d, required 0", cursor);
        end
    endtask

    task automatic test_clear_after_reset();
        int d;
        int gaps = 0;
        clear_logs();
        m_cursor = 0;
        exp_clear();
        rst = 1'b1;
        tick(1);
        total++;
        if (busy !== 1'b1 || regwrite !== 1'b0) begin
            bad++;
            $display("FAIL clr_start: busy=%0b regwrite=%0b, required 1 0", busy, regwrite);
        end
        wait_busy(1'b0, 600, "clr_done");
        tick(3);
        d = log_diff();
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL clr_seq: at %0d got %0d exp %0d (writes %0d, required %0d)",
                     d, got_at(d), exp_at(d), got_q.size(), exp_q.size());
        end
        for (int i = 1; i < got_c.size(); i++) if (got_c[i] != got_c[i-1] + 1) gaps++;
        total++;
        if (gaps != 0) begin
            bad++;
            $display("FAIL clr_consecutive: %0d gaps, required 0", gaps);
        end
    endtask

    task automatic test_clear_pause();
        int d;
        int k = 0;
        int hi_seen = 0;
        clear_logs();
        exp_clear();
        pulse_clr();
        while (!(regwrite === 1'b1 && addr_in === 8'd100) && k < 600) begin
            tick(1);
            k++;
        end
        total++;
        if (addr_in !== 8'd100) begin
            bad++;
            $display("FAIL pause_reach: addr=%0d, required 100", addr_in);
        end
        vblank = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (regwrite !== 1'b0) hi_seen++;
        end
        total++;
        if (hi_seen != 0) begin
            bad++;
            $display("FAIL pause_quiet: %0d writes while vblank low, required 0", hi_seen);
        end
        vblank = 1'b1;
        tick(1);
        total++;
        if (regwrite !== 1'b1 || addr_in !== 8'd101) begin
            bad++;
            $display("FAIL pause_resume: regwrite=%0b addr=%0d, required 1 101", regwrite, addr_in);
        end
        wait_busy(1'b0, 600, "pause_done");
        tick(3);
        d = log_diff();
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL pause_seq: at %0d got %0d exp %0d (writes %0d, required %0d)",
                     d, got_at(d), exp_at(d), got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_clear_random_vblank();
        int d;
        int k = 0;
        int viol = 0;
        bit prev;
        clear_logs();
        exp_clear();
        pulse_clr();
        wait_busy(1'b1, 5, "rvb_start");
        while (busy === 1'b1 && k < 3000) begin
            vblank = ($urandom_range(0, 3) != 0);
            prev = vblank;
            tick(1);
            if (regwrite === 1'b1 && !prev) viol++;
            k++;
        end
        vblank = 1'b1;
        tick(3);
        total++;
        if (viol != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rvb_gate: %0d writes outside vblank busy=%0b, required 0 0", viol, busy);
        end
        d = log_diff();
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL rvb_seq: at %0d got %0d exp %0d (writes %0d, required %0d)",
                     d, got_at(d), exp_at(d), got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_move_right();
        int d;
        clear_logs();
        vblank = 1'b1;
        exp_move(1'b1);
        press(1'b1, 1'b0, 10);
        d = log_diff();
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL right_seq: at %0d got %0d exp %0d (writes %0d, required %0d)",
                     d, got_at(d), exp_at(d), got_q.size(), exp_q.size());
        end
        total++;
        if (got_c.size() != 2 || got_c[1] != got_c[0] + 1) begin
            bad++;
            $display("FAIL right_b2b: %0d writes not back-to-back, required 2 adjacent", got_c.size());
        end
        total++;
        if (cursor !== 8'(m_cursor)) begin
            bad++;
            $display("FAIL right_cursor: cursor=%0d, required %0d", cursor, m_cursor);
        end
        clear_logs();
        press(1'b1, 1'b0, 2);
        total++;
        if (got_q.size() != 0) begin
            bad++;
            $display("FAIL glitch: %0d writes, required 0", got_q.size());
        end
    endtask

    task automatic test_wrap();
        int d;
        int mid;
        clear_logs();
        vblank = 1'b1;
        exp_move(1'b0);
        press(1'b0, 1'b1, 8);
        exp_move(1'b0);
        press(1'b0, 1'b1, 8);
        mid = int'(cursor);
        total++;
        if (mid != 255 || m_cursor != 255) begin
            bad++;
            $display("FAIL wrap_down: cursor=%0d, required %0d", mid, m_cursor);
        end
        exp_move(1'b1);
        press(1'b1, 1'b0, 8);
        d = log_diff();
        total++;
        if (d != -1 || cursor !== 8'(m_cursor)) begin
            bad++;
            $display("FAIL wrap_seq: at %0d got %0d exp %0d cursor=%0d required %0d",
                     d, got_at(d), exp_at(d), cursor, m_cursor);
        end
    endtask

    task automatic test_random_moves();
        int d;
        bit r;
        clear_logs();
        vblank = 1'b1;
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 1);
            exp_move(r);
            press(r, !r, $urandom_range(6, 12));
        end
        d = log_diff();
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL rand_seq: at %0d got %0d exp %0d (writes %0d, required %0d)",
                     d, got_at(d), exp_at(d), got_q.size(), exp_q.size());
        end
        total++;
        if (cursor !== 8'(m_cursor)) begin
            bad++;
            $display("FAIL rand_cursor: cursor=%0d, required %0d", cursor, m_cursor);
        end
    endtask

    task automatic test_atomic();
        int d;
        int k = 0;
        clear_logs();
        vblank = 1'b1;
        exp_move(1'b1);
        bntr = 1'b1;
        while (regwrite !== 1'b1 && k < 30) begin
            tick(1);
            k++;
        end
        vblank = 1'b0;
        tick(1);
        total++;
        if (regwrite !== 1'b1 || data_in !== 3'b100) begin
            bad++;
            $display("FAIL atomic_paint: regwrite=%0b data=%0d, required 1 4", regwrite, data_in);
        end
        bntr = 1'b0;
        tick(14);
        vblank = 1'b1;
        tick(3);
        d = log_diff();
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL atomic_seq: at %0d got %0d exp %0d (writes %0d, required %0d)",
                     d, got_at(d), exp_at(d), got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_both_pending();
        int d;
        int c0;
        clear_logs();
        vblank = 1'b0;
        c0 = m_cursor;
        press(1'b1, 1'b1, 10);
        vblank = 1'b1;
        tick(6);
        total++;
        if (got_q.size() != 0 || cursor !== 8'(c0)) begin
            bad++;
            $display("FAIL both_cancel: %0d writes cursor=%0d, required 0 %0d", got_q.size(), cursor, c0);
        end
        vblank = 1'b0;
        press(1'b1, 1'b0, 10);
        tick(10);
        total++;
        if (got_q.size() != 0) begin
            bad++;
            $display("FAIL held_off: %0d writes while vblank low, required 0", got_q.size());
        end
        exp_move(1'b1);
        vblank = 1'b1;
        tick(8);
        d = log_diff();
        total++;
        if (d != -1 || cursor !== 8'(m_cursor)) begin
            bad++;
            $display("FAIL late_move: at %0d got %0d exp %0d cursor=%0d required %0d",
                     d, got_at(d), exp_at(d), cursor, m_cursor);
        end
    endtask

    task automatic test_back_to_back_clear();
        int d;
        clear_logs();
        vblank = 1'b1;
        exp_clear();
        exp_clear();
        pulse_clr();
        wait_busy(1'b1, 5, "b2b_start");
        tick(20);
        pulse_clr();
        tick(30);
        pulse_clr();
        wait_busy(1'b0, 600, "b2b_first");
        wait_busy(1'b1, 5, "b2b_second");
        wait_busy(1'b0, 600, "b2b_done");
        tick(40);
        d = log_diff();
        total++;
        if (d != -1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_seq: at %0d got %0d exp %0d (writes %0d, required %0d) busy=%0b",
                     d, got_at(d), exp_at(d), got_q.size(), exp_q.size(), busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        int d;
        int k = 0;
        vblank = 1'b1;
        pulse_clr();
        while (!(regwrite === 1'b1 && addr_in >= 8'd50) && k < 600) begin
            tick(1);
            k++;
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({addr_in, data_in, regwrite, cursor, busy} !== 21'd0) begin
            bad++;
            $display("FAIL async_reset: addr=%0d data=%0d we=%0b cursor=%0d busy=%0b, required all 0",
                     addr_in, data_in, regwrite, cursor, busy);
        end
        tick(3);
        clear_logs();
        m_cursor = 0;
        exp_clear();
        rst = 1'b1;
        wait_busy(1'b1, 5, "rst_restart");
        wait_busy(1'b0, 600, "rst_done");
        tick(3);
        d = log_diff();
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL rst_seq: at %0d got %0d exp %0d (writes %0d, required %0d)",
                     d, got_at(d), exp_at(d), got_q.size(), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_clear_after_reset();
        test_clear_pause();
        test_clear_random_vblank();
        test_move_right();
        test_wrap();
        test_random_moves();
        test_atomic();
        test_both_pending();
        test_back_to_back_clear();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
